// File: rtl/spi_burst_arbiter.sv
// Round-robin burst arbiter sharing one byte-level SPI master between NREQ clients.
// Handshake: a client holds req[i] (with req_data/req_last stable) until ack[i] pulses for one cycle.
module spi_burst_arbiter #(
    parameter int NREQ     = 2,
    parameter int START_TO = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_last,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [2:0]        gnt_idx,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        rdata,
    output logic              rerr,
    output logic              spi_start,
    output logic [7:0]        spi_dout,
    input  logic              spi_busy,
    input  logic [7:0]        spi_din,
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic       last;
    logic [7:0] wdog;

    logic       owner_req;
    logic       owner_last;
    logic [7:0] owner_data;
    logic       pick_found;
    logic [2:0] pick_idx;
    logic [2:0] next_ptr;

    assign fsm_state = state;

    always_comb begin
        owner_req  = |(req & gnt);
        owner_last = |(req_last & gnt);
        owner_data = '0;
        pick_found = 1'b0;
        pick_idx   = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == 3'(i)) owner_data = req_data[8*i +: 8];
        end
        // Lowest priority written first so the client nearest ptr (upward, wrapping) wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (3'(i) < ptr)) begin
                pick_found = 1'b1;
                pick_idx   = 3'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (3'(i) >= ptr)) begin
                pick_found = 1'b1;
                pick_idx   = 3'(i);
            end
        end
        next_ptr = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            ack       <= '0;
            rdata     <= '0;
            rerr      <= 1'b0;
            spi_start <= 1'b0;
            spi_dout  <= '0;
            ptr       <= '0;
            last      <= 1'b0;
            wdog      <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    // An open burst belongs to its owner; other clients wait for it to close.
                    if (|gnt) begin
                        if (owner_req) state <= ISSUE;
                    end else if (pick_found && !spi_busy) begin
                        gnt     <= NREQ'(1) << pick_idx;
                        gnt_idx <= pick_idx;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    spi_dout  <= owner_data;
                    last      <= owner_last;
                    spi_start <= 1'b1;
                    wdog      <= '0;
                    state     <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (spi_busy) begin
                        spi_start <= 1'b0;
                        state     <= WAIT_FALL;
                    end else if (wdog + 8'd1 == 8'(START_TO)) begin
                        spi_start <= 1'b0;
                        rerr      <= 1'b1;
                        rdata     <= '0;
                        ack       <= gnt;
                        state     <= RESP;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                WAIT_FALL: begin
                    if (!spi_busy) begin
                        rdata <= spi_din;
                        rerr  <= 1'b0;
                        ack   <= gnt;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (last || rerr) begin
                        gnt   <= '0;
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end else if (owner_req) begin
                        state <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Bench for spi_burst_arbiter: behavioural SPI master, client driver, ack scoreboard,
// a vector table for single-byte arbitration and hand sequences for burst/abort/reset cases.
module tb_spi_burst_arbiter;

    localparam int NREQ     = 2;
    localparam int START_TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  req_last = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  gnt;
    logic [2:0]  gnt_idx;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic        rerr;
    logic        spi_start;
    logic [7:0]  spi_dout;
    logic        spi_busy = 1'b0;
    logic [7:0]  spi_din = '0;
    logic [2:0]  fsm_state;

    int checks = 0;
    int failures = 0;

    spi_burst_arbiter #(.NREQ(NREQ), .START_TO(START_TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last), .req_data(req_data),
        .gnt(gnt), .gnt_idx(gnt_idx), .ack(ack), .rdata(rdata), .rerr(rerr),
        .spi_start(spi_start), .spi_dout(spi_dout), .spi_busy(spi_busy), .spi_din(spi_din),
        .fsm_state(fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    // SPI master model: answers START with a BUSY pulse of mm_len cycles, DIN = DOUT ^ mm_xor
    bit         mm_en = 1'b0;
    bit         mm_force = 1'b0;
    int         mm_len = 3;
    logic [7:0] mm_xor = '0;
    int         mm_starts = 0;
    int         mm_high = 0;
    bit         mm_prev = 1'b0;
    bit         mm_busy = 1'b0;
    int         mm_cnt = 0;
    logic [7:0] mm_lat = '0;

    always @(negedge clk) begin
        if (spi_start && !mm_prev) mm_starts++;
        if (spi_start) mm_high++;
        mm_prev = spi_start;
        if (mm_busy) begin
            mm_cnt--;
            if (mm_cnt <= 0) begin
                mm_busy = 1'b0;
                spi_din = mm_lat ^ mm_xor;
            end
        end else if (mm_en && spi_start) begin
            mm_busy = 1'b1;
            mm_cnt  = mm_len;
            mm_lat  = spi_dout;
        end
        spi_busy = mm_force | mm_busy;
    end

    // ack monitor: records {client, rdata, rerr} for every ack pulse
    logic [11:0] obs_q[$];
    logic [11:0] exp_q[$];
    bit          multi_ack = 1'b0;

    always @(negedge clk) begin
        if (rst_n && ack != 2'b00) begin
            if ($countones(ack) != 1) multi_ack = 1'b1;
            obs_q.push_back({(ack[1] ? 3'd1 : 3'd0), rdata, rerr});
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_sb(input string name);
        check({name, "_ack_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check({name, "_ack"}, obs_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // client driver: per-client byte queues {last, data}, optional gap after each ack
    // and an ack count before a client starts requesting
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int gap1 = 0;
    int after0 = 0;

    task automatic run_clients(input string name, input int budget);
        int acks;
        int w1;
        bit done;
        acks = 0;
        w1 = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(negedge clk);
            if (ack[0] && q0.size() > 0) begin
                void'(q0.pop_front());
                acks++;
            end
            if (ack[1] && q1.size() > 0) begin
                void'(q1.pop_front());
                acks++;
                w1 = gap1;
            end
            req[0] = (q0.size() > 0) && (acks >= after0);
            if (q0.size() > 0) begin
                req_data[7:0] = q0[0][7:0];
                req_last[0]   = q0[0][8];
            end
            req[1] = (q1.size() > 0) && (w1 == 0);
            if (w1 > 0) w1--;
            if (q1.size() > 0) begin
                req_data[15:8] = q1[0][7:0];
                req_last[1]    = q1[0][8];
            end
            done = (q0.size() == 0) && (q1.size() == 0) && (gnt == 2'b00);
        end
        check({name, "_done"}, done, 1);
        req = '0;
        q0.delete();
        q1.delete();
    endtask

    typedef struct {
        logic [1:0] mask;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] xr;
        logic [2:0] win;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int s0;
        int h0;
        bit got;
        bit seen;

        vecs[0] = '{2'b01, 8'hA5, 8'h00, 8'h99, 3'd0, 8'h3C};
        vecs[1] = '{2'b11, 8'h11, 8'h22, 8'hFF, 3'd1, 8'hDD};
        vecs[2] = '{2'b11, 8'h33, 8'h44, 8'hFF, 3'd0, 8'hCC};
        vecs[3] = '{2'b01, 8'h55, 8'h00, 8'hFF, 3'd0, 8'hAA};
        vecs[4] = '{2'b10, 8'h00, 8'h0F, 8'hFF, 3'd1, 8'hF0};
        vecs[5] = '{2'b10, 8'h00, 8'h80, 8'hFF, 3'd1, 8'h7F};
        vecs[6] = '{2'b11, 8'h01, 8'h02, 8'hFF, 3'd0, 8'hFE};
        vecs[7] = '{2'b11, 8'hF0, 8'h5A, 8'hFF, 3'd1, 8'hA5};

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_gnt_idx", gnt_idx, 0);
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rerr", rerr, 0);
        check("rst_start", spi_start, 0);
        check("rst_dout", spi_dout, 0);
        rst_n = 1'b1;
        mm_en = 1'b1;
        mm_len = 3;
        @(negedge clk);

        // single-byte LAST transactions, round-robin winner per table
        for (int i = 0; i < 8; i++) begin
            mm_xor   = vecs[i].xr;
            s0       = mm_starts;
            req_data = {vecs[i].d1, vecs[i].d0};
            req_last = 2'b11;
            req      = vecs[i].mask;
            exp_q.push_back({vecs[i].win, vecs[i].exp_rdata, 1'b0});
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                if (ack != 2'b00) got = 1'b1;
            end
            check($sformatf("vec%0d_ack_seen", i), got, 1);
            check($sformatf("vec%0d_gnt_idx", i), gnt_idx, vecs[i].win);
            check($sformatf("vec%0d_dout", i), spi_dout, (vecs[i].win == 3'd1) ? vecs[i].d1 : vecs[i].d0);
            req = '0;
            @(negedge clk);
            check($sformatf("vec%0d_gnt_clear", i), gnt, 0);
            check($sformatf("vec%0d_starts", i), mm_starts - s0, 1);
            check_sb($sformatf("vec%0d", i));
        end

        // simultaneous 3-byte bursts: client 0 completes first, then client 1
        mm_xor = 8'hFF;
        q0 = '{9'h010, 9'h020, 9'h130};
        q1 = '{9'h040, 9'h050, 9'h160};
        exp_q = '{{3'd0, 8'hEF, 1'b0}, {3'd0, 8'hDF, 1'b0}, {3'd0, 8'hCF, 1'b0},
                  {3'd1, 8'hBF, 1'b0}, {3'd1, 8'hAF, 1'b0}, {3'd1, 8'h9F, 1'b0}};
        run_clients("burst2", 400);
        check_sb("burst2");

        // client 0 alone moves the pointer to 1; next simultaneous request goes to client 1
        q0 = '{9'h177};
        exp_q = '{{3'd0, 8'h88, 1'b0}};
        run_clients("solo0", 100);
        check_sb("solo0");
        q0 = '{9'h101};
        q1 = '{9'h102};
        exp_q = '{{3'd1, 8'hFD, 1'b0}, {3'd0, 8'hFE, 1'b0}};
        run_clients("rr_next", 200);
        check_sb("rr_next");

        // client 0 joins while client 1's burst is open (with idle gaps) and must wait
        after0 = 1;
        gap1 = 3;
        q1 = '{9'h00A, 9'h00B, 9'h10C};
        q0 = '{9'h10D};
        exp_q = '{{3'd1, 8'hF5, 1'b0}, {3'd1, 8'hF4, 1'b0}, {3'd1, 8'hF3, 1'b0},
                  {3'd0, 8'hF2, 1'b0}};
        run_clients("open_burst", 400);
        check_sb("open_burst");
        after0 = 0;
        gap1 = 0;

        // watchdog abort: master never raises BUSY
        mm_en = 1'b0;
        h0 = mm_high;
        q1 = '{9'h066};
        exp_q = '{{3'd1, 8'h00, 1'b1}};
        run_clients("abort", 100);
        check("abort_start_cycles", mm_high - h0, START_TO);
        check_sb("abort");
        mm_en = 1'b1;
        q0 = '{9'h112};
        q1 = '{9'h134};
        exp_q = '{{3'd0, 8'hED, 1'b0}, {3'd1, 8'hCB, 1'b0}};
        run_clients("after_abort", 200);
        check_sb("after_abort");

        // BUSY held across reset blocks arbitration
        mm_en = 1'b0;
        mm_force = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req_data[7:0] = 8'h5C;
        req_last = 2'b01;
        req = 2'b01;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (gnt != 2'b00) seen = 1'b1;
        end
        check("busy_blocks_gnt", seen, 0);
        mm_force = 1'b0;
        mm_en = 1'b1;
        q0 = '{9'h15C};
        exp_q = '{{3'd0, 8'hA3, 1'b0}};
        run_clients("busy_release", 100);
        check_sb("busy_release");

        // reset during WAIT_FALL
        mm_len = 20;
        req_data[7:0] = 8'h21;
        req_last = 2'b01;
        req = 2'b01;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (fsm_state == 3'd3) got = 1'b1;
        end
        check("wf_reached", got, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("wf_rst_gnt", gnt, 0);
        check("wf_rst_gnt_idx", gnt_idx, 0);
        check("wf_rst_ack", ack, 0);
        check("wf_rst_start", spi_start, 0);
        check("wf_rst_dout", spi_dout, 0);
        check("wf_rst_rdata", rdata, 0);
        check("wf_rst_rerr", rerr, 0);
        req = '0;
        @(negedge clk);
        check("wf_rst_ack2", ack, 0);
        rst_n = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (!spi_busy) got = 1'b1;
        end
        check("wf_busy_fall", got, 1);
        check("wf_no_gnt", gnt, 0);
        check_sb("wf_no_ack");
        mm_len = 3;
        q0 = '{9'h1C3};
        q1 = '{9'h13C};
        exp_q = '{{3'd0, 8'h3C, 1'b0}, {3'd1, 8'hC3, 1'b0}};
        run_clients("post_reset", 200);
        check_sb("post_reset");

        check("single_ack_bit", multi_ack, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
